// File: rtl/nor_reduce_pipe.sv
// nor_reduce_pipe: pipelined WIDTH-bit zero/ones detector for FP operand
// classification. Each registered stage folds RADIX-bit groups with OR
// (mode 0, all-zero detect) or AND (mode 1, all-ones detect). The NOR
// inversion is applied only at the final stage. Mode and tag ride along
// with the data. One global advance signal moves every stage at once.
// Optional feature macro: NOR_REDUCE_PIPE_HIT_CNT_EN (saturating count of
// delivered results whose flag is 1).
`timescale 1ns/1ps

module nor_reduce_pipe #(
    parameter int WIDTH = 64,
    parameter int RADIX = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_flag,
    output logic             out_mode,
    output logic [TAG_W-1:0] out_tag,
    output logic [15:0]      hit_cnt,
    input  logic             cnt_clr
);

    // Vector width entering stage k (stage 0 sees the raw operand).
    function automatic int stage_w(input int k);
        int n;
        n = WIDTH;
        for (int i = 0; i < k; i++) n = (n + RADIX - 1) / RADIX;
        return n;
    endfunction

    // Number of stages needed to fold WIDTH bits down to one (at least 1).
    function automatic int num_stages();
        int n;
        int s;
        n = WIDTH;
        s = 0;
        while (n > 1) begin
            n = (n + RADIX - 1) / RADIX;
            s++;
        end
        return (s < 1) ? 1 : s;
    endfunction

    // Bit offset of registered stage k (1-based) inside the packed data_q.
    function automatic int stage_off(input int k);
        int o;
        o = 0;
        for (int j = 1; j < k; j++) o += stage_w(j);
        return o;
    endfunction

    localparam int STAGES = num_stages();
    localparam int TOTAL  = stage_off(STAGES + 1);

    logic                        adv;
    logic [TOTAL-1:0]            data_q;
    logic [TOTAL-1:0]            data_d;
    logic [STAGES:1]             valid_q;
    logic [STAGES:1]             valid_d;
    logic [STAGES:1]             mode_q;
    logic [STAGES:1]             mode_d;
    logic [STAGES:1][TAG_W-1:0]  tag_q;
    logic [STAGES:1][TAG_W-1:0]  tag_d;

    // Whole pipeline moves together; it only freezes when the output is
    // occupied and the consumer refuses it.
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    // Combinational fold for each stage; results land in that stage's slice
    // of data_d.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int IW  = stage_w(k);
        localparam int OW  = stage_w(k + 1);
        localparam int OFF = stage_off(k + 1);

        logic [IW-1:0] src;
        logic          src_mode;
        logic [OW-1:0] red;

        if (k == 0) begin : g_first
            assign src      = in_data;
            assign src_mode = in_mode;
        end else begin : g_inner
            assign src      = data_q[stage_off(k) +: IW];
            assign src_mode = mode_q[k];
        end

        // A short last group simply folds fewer bits, which is the same as
        // padding with the identity value (0 for OR, 1 for AND).
        for (genvar g = 0; g < OW; g++) begin : g_grp
            localparam int LO = g * RADIX;
            localparam int GW = (IW - LO < RADIX) ? (IW - LO) : RADIX;
            logic [GW-1:0] grp;
            assign grp    = src[LO +: GW];
            assign red[g] = src_mode ? (&grp) : (|grp);
        end

        if (k == STAGES - 1) begin : g_last
            // Only the final stage turns the OR into a NOR.
            assign data_d[OFF] = src_mode ? red[0] : ~red[0];
        end else begin : g_mid
            assign data_d[OFF +: OW] = red;
        end
    end

    // Sideband shift: stage 1 takes the new input, stage k takes stage k-1.
    always_comb begin
        // NOTE: every always_comb output gets a full default first so no
        // path leaves it unassigned and a latch is never inferred.
        valid_d    = valid_q << 1;
        mode_d     = mode_q << 1;
        tag_d      = tag_q << TAG_W;
        valid_d[1] = in_valid;
        mode_d[1]  = in_mode;
        tag_d[1]   = in_tag;
    end

    // Pipeline registers: cleared on reset, advanced together when adv=1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking updates so every stage samples the value
            // its predecessor held before this edge.
            valid_q <= '0;
            mode_q  <= '0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (adv) begin
            valid_q <= valid_d;
            mode_q  <= mode_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q[STAGES];
    assign out_mode  = mode_q[STAGES];
    assign out_tag   = tag_q[STAGES];
    assign out_flag  = data_q[TOTAL-1];

`ifdef NOR_REDUCE_PIPE_HIT_CNT_EN
    // Saturating count of delivered flag-true results; clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt <= '0;
        end else if (cnt_clr) begin
            hit_cnt <= '0;
        end else if (out_valid && out_ready && out_flag && (hit_cnt != 16'hFFFF)) begin
            hit_cnt <= hit_cnt + 16'd1;
        end
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign hit_cnt        = '0;
`endif

endmodule

// File: tb/tb_nor_reduce_pipe.sv
// Self-checking bench for nor_reduce_pipe: a 64-bit/radix-8 instance for the
// main checks and an 11-bit instance for partial-group padding.
`timescale 1ns/1ps

module tb_nor_reduce_pipe;

    localparam int NV = 13;

`ifdef NOR_REDUCE_PIPE_HIT_CNT_EN
    localparam logic [15:0] EXP_HIT3 = 16'd3;
    localparam logic [15:0] EXP_SAT  = 16'hFFFF;
`else
    localparam logic [15:0] EXP_HIT3 = 16'd0;
    localparam logic [15:0] EXP_SAT  = 16'd0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_mode, out_valid, out_ready;
    logic        out_flag, out_mode, cnt_clr;
    logic [63:0] in_data;
    logic [3:0]  in_tag, out_tag;
    logic [15:0] hit_cnt;

    logic        b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready;
    logic        b_out_flag, b_out_mode;
    logic [10:0] b_in_data;
    logic [3:0]  b_in_tag, b_out_tag;
    logic [15:0] b_hit_cnt;

    int checks   = 0;
    int failures = 0;
    int got, first_c, last_c;

    typedef struct {
        logic [63:0] data;
        logic        mode;
        logic [3:0]  tag;
        logic        flag;
    } vec_t;

    vec_t vecs [NV];

    always #5 clk = ~clk;

    nor_reduce_pipe #(.WIDTH(64), .RADIX(8), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_flag(out_flag),
        .out_mode(out_mode), .out_tag(out_tag),
        .hit_cnt(hit_cnt), .cnt_clr(cnt_clr)
    );

    nor_reduce_pipe #(.WIDTH(11), .RADIX(8), .TAG_W(4)) dut11 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_mode(b_in_mode), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_flag(b_out_flag),
        .out_mode(b_out_mode), .out_tag(b_out_tag),
        .hit_cnt(b_hit_cnt), .cnt_clr(1'b0)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send11(input string name, input logic [10:0] d, input logic m,
                          input logic exp_flag);
        b_in_valid = 1'b1;
        b_in_data  = d;
        b_in_mode  = m;
        step();
        b_in_valid = 1'b0;
        step();
        check({name, "_valid"}, 64'(b_out_valid), 64'(1));
        check({name, "_flag"}, 64'(b_out_flag), 64'(exp_flag));
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            vecs[i].data = (i % 2 == 0) ? 64'h0 : (64'h1 << (i * 9));
            vecs[i].mode = 1'b0;
            vecs[i].tag  = 4'(i);
            vecs[i].flag = (i % 2 == 0);
        end
        vecs[8]  = '{data: 64'hFFFF_FFFF_FFFF_FFFF, mode: 1'b1, tag: 4'd8,  flag: 1'b1};
        vecs[9]  = '{data: 64'h7FFF_FFFF_FFFF_FFFF, mode: 1'b1, tag: 4'd9,  flag: 1'b0};
        vecs[10] = '{data: 64'h8000_0000_0000_0000, mode: 1'b0, tag: 4'd10, flag: 1'b0};
        vecs[11] = '{data: 64'h0,                   mode: 1'b1, tag: 4'd11, flag: 1'b0};
        vecs[12] = '{data: 64'hFFFF_FFFF_FFFF_FEFF, mode: 1'b1, tag: 4'd12, flag: 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; in_tag = '0;
        out_ready = 1'b1; cnt_clr = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_in_mode = 1'b0; b_in_tag = '0;
        b_out_ready = 1'b1;
        #23 rst_n = 1'b1;
        #1;

        // Reset state
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_flag", 64'(out_flag), 64'(0));
        check("rst_out_mode", 64'(out_mode), 64'(0));
        check("rst_out_tag", 64'(out_tag), 64'(0));
        check("rst_hit_cnt", 64'(hit_cnt), 64'(0));

        // Latency of two cycles; in_data is X while idle
        step();
        in_valid = 1'b1; in_data = 64'h0; in_mode = 1'b0; in_tag = 4'd3;
        step();
        in_valid = 1'b0; in_data = 'x;
        check("lat_early_valid", 64'(out_valid), 64'(0));
        step();
        check("lat_valid", 64'(out_valid), 64'(1));
        check("lat_flag", 64'(out_flag), 64'(1));
        check("lat_tag", 64'(out_tag), 64'(3));
        step();
        check("lat_bubble", 64'(out_valid), 64'(0));
        in_valid = 1'b1; in_data = 64'h0000_0000_0000_0100; in_mode = 1'b0; in_tag = 4'd5;
        step();
        in_valid = 1'b0; in_data = 'x;
        step();
        check("nz_valid", 64'(out_valid), 64'(1));
        check("nz_flag", 64'(out_flag), 64'(0));
        check("nz_tag", 64'(out_tag), 64'(5));
        step();

        // Back-to-back table
        got = 0; first_c = -1; last_c = -1;
        fork
            begin
                for (int i = 0; i < NV; i++) begin
                    in_valid = 1'b1;
                    in_data  = vecs[i].data;
                    in_mode  = vecs[i].mode;
                    in_tag   = vecs[i].tag;
                    step();
                end
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 40 && got < NV; c++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        check($sformatf("tbl%0d_flag", got), 64'(out_flag), 64'(vecs[got].flag));
                        check($sformatf("tbl%0d_tag", got), 64'(out_tag), 64'(vecs[got].tag));
                        check($sformatf("tbl%0d_mode", got), 64'(out_mode), 64'(vecs[got].mode));
                        if (got == 0) first_c = c;
                        last_c = c;
                        got++;
                    end
                end
            end
        join
        check("tbl_count", 64'(got), 64'(NV));
        check("tbl_span", 64'(last_c - first_c), 64'(NV - 1));
        step();
        check("tbl_drained", 64'(out_valid), 64'(0));

        // Stall with two results in flight
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'h0; in_mode = 1'b0; in_tag = 4'd1;
        step();
        in_data = 64'hF0; in_tag = 4'd2;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("stall%0d_valid", i), 64'(out_valid), 64'(1));
            check($sformatf("stall%0d_tag", i), 64'(out_tag), 64'(1));
            check($sformatf("stall%0d_flag", i), 64'(out_flag), 64'(1));
            check($sformatf("stall%0d_in_ready", i), 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        step();
        check("unstall_valid", 64'(out_valid), 64'(1));
        check("unstall_tag", 64'(out_tag), 64'(2));
        check("unstall_flag", 64'(out_flag), 64'(0));
        step();
        check("unstall_empty", 64'(out_valid), 64'(0));

        // Asynchronous reset mid-stream
        in_valid = 1'b1; in_data = 64'h0; in_tag = 4'd6;
        step();
        in_tag = 4'd7;
        step();
        in_valid = 1'b0;
        check("pre_rst_valid", 64'(out_valid), 64'(1));
        #3 rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'(0));
        check("arst_in_ready", 64'(in_ready), 64'(1));
        check("arst_tag", 64'(out_tag), 64'(0));
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("post_rst%0d_valid", i), 64'(out_valid), 64'(0));
        end
        check("post_rst_in_ready", 64'(in_ready), 64'(1));

        // 11-bit instance: padded last group
        send11("w11_ones_and", 11'h7FF, 1'b1, 1'b1);
        send11("w11_7fe_and", 11'h7FE, 1'b1, 1'b0);
        send11("w11_zero_nor", 11'h000, 1'b0, 1'b1);
        send11("w11_msb_nor", 11'h400, 1'b0, 1'b0);
        send11("w11_3ff_and", 11'h3FF, 1'b1, 1'b0);

        // Hit counter: start clean
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        step();
        check("hit_after_rst", 64'(hit_cnt), 64'(0));
        in_valid = 1'b1; in_data = 64'h0; in_mode = 1'b0;
        repeat (3) step();
        in_valid = 1'b0;
        repeat (3) step();
        check("hit_three", 64'(hit_cnt), 64'(EXP_HIT3));

        // Clear coincident with a hit
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("clr_hit_present", 64'(out_valid & out_flag), 64'(1));
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("clr_wins", 64'(hit_cnt), 64'(0));

`ifdef NOR_REDUCE_PIPE_HIT_CNT_EN
        in_valid = 1'b1; in_data = 64'h0; in_mode = 1'b0;
        repeat (65540) step();
        in_valid = 1'b0;
        repeat (3) step();
`endif
        check("hit_saturate", 64'(hit_cnt), 64'(EXP_SAT));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nor_reduce_pipe.md
Name: nor_reduce_pipe

Overview:
- Parametrised, pipelined successor to the 2-input NOR gate: reduces a WIDTH-bit operand to one flag through a tree of registered RADIX-input stages.
- Per-transaction mode selects NOR reduction (all-zero detect, for zero mantissa/exponent) or AND reduction (all-ones detect, for exponent Inf/NaN).
- Sits in the FP multiplier's operand-classification path.
- Valid/ready handshake with global stall; a tag field travels with each result.

Parameters:
- WIDTH, 64, operand width in bits (>=1).
- RADIX, 8, bits combined per stage per group (>=2).
- TAG_W, 4, width of the passthrough tag (>=1).
- STAGES (localparam): max(1, ceil(log_RADIX(WIDTH))). For WIDTH=64, RADIX=8 this is 2; for WIDTH=11, RADIX=8 it is 2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand present
- in_ready  out  1  block accepts the operand this cycle
- in_data  in  WIDTH  operand
- in_mode  in  1  0 = NOR (all-zero), 1 = AND (all-ones)
- in_tag  in  TAG_W  user tag
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts the result
- out_flag  out  1  reduction result
- out_mode  out  1  mode of this result
- out_tag  out  TAG_W  tag of this result
- hit_cnt  out  16  flag-true count (see Optional Feature)
- cnt_clr  in  1  synchronous clear of hit_cnt

Behaviour:
- Reset (rst_n low, asynchronous): every stage valid bit, out_valid, out_flag, out_mode, out_tag and hit_cnt go to 0. in_ready reads 1 immediately after reset.
- Global advance: adv = out_ready | ~out_valid, and in_ready = adv. All stages shift together when adv=1 and hold everything when adv=0. Bubbles are not collapsed.
- Transfer in: in_valid & in_ready. Stage-1 valid loads in_valid when adv=1, so a non-transfer shifts in a bubble.
- Stage k: splits its input vector into ceil(n/RADIX) groups of RADIX bits, LSB-aligned.
  - Each group reduces with OR when mode=0 and AND when mode=1.
  - The last partial group pads with the identity value: 0 for OR, 1 for AND.
- Final stage output: out_flag = ~(OR of all bits) when mode=0, and AND of all bits when mode=1. The inversion is applied only at the last stage.
- Mode and tag are pipelined alongside the data.
- Latency: exactly STAGES cycles from the transfer-in edge to out_valid=1 when unstalled. Throughput is 1 per cycle.
- Stall: while out_valid=1 and out_ready=0, out_* stay stable and in_ready=0. A pending in_valid must hold its data (standard valid/ready rule).
- Data fields of stages whose valid bit is 0 are don't-care. out_flag, out_mode and out_tag change only on advance.
- Reset mid-operation: all in-flight results are discarded and no output is produced for them after reset.
- X on in_data while in_valid=0 must not propagate to out_valid.

Optional Feature:
- Macro: NOR_REDUCE_PIPE_HIT_CNT_EN.
- Defined:
  - hit_cnt increments by 1 on each output transfer (out_valid & out_ready) with out_flag=1.
  - hit_cnt saturates at 16'hFFFF.
  - cnt_clr=1 zeroes it on the next edge. If clear and increment coincide, clear wins.
- Not defined: hit_cnt is tied to 0, cnt_clr is ignored, and no counter flops are built.

Test Plan:
- Defaults, out_ready=1: send in_data=0 mode=0 tag=3 -> two cycles later out_valid=1, out_flag=1, out_tag=3. Then send 64'h0000_0000_0000_0100 mode=0 -> out_flag=0.
- AND mode with padding (WIDTH=11): in_data=11'h7FF mode=1 -> out_flag=1; 11'h7FE mode=1 -> out_flag=0. WIDTH=11, mode=0, data=0 -> out_flag=1, so the padding must not corrupt the result.
- Back-to-back: 8 consecutive transfers with tags 0..7 and alternating zero/nonzero data -> 8 consecutive out_valid cycles with tags in order and flags 1,0,1,0,...
- Stall: hold out_ready=0 for 5 cycles with 2 results in flight -> out_* stable, in_ready=0. Release -> both results delivered in order with no loss or duplication.
- Async reset: assert rst_n low mid-stream between clock edges -> out_valid drops immediately. After release, no stale results appear and in_ready=1.
- With NOR_REDUCE_PIPE_HIT_CNT_EN:
  - 3 zero results -> hit_cnt=3.
  - cnt_clr coincident with a hit -> hit_cnt=0.
  - Preload near 16'hFFFF via repeated hits -> hit_cnt holds at 16'hFFFF.
  - Without the macro, hit_cnt stays 0 throughout.
